// File: rtl/seed_arbiter.sv
// Seed arbiter: holds one conditioned seed and hands it to either the DRBG
// (priority) or the RDSEED buffer, with a starvation limit and grant statistics.
module seed_arbiter #(
  parameter int unsigned DATA_WIDTH   = 256,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  cond_valid_i,
  output logic                  cond_ready_o,
  input  logic [DATA_WIDTH-1:0] cond_seed_i,

  input  logic                  drbg_req_i,
  input  logic                  drbg_ready_i,
  output logic                  drbg_valid_o,
  output logic [DATA_WIDTH-1:0] drbg_seed_o,

  input  logic                  rdseed_ready_i,
  output logic                  rdseed_valid_o,
  output logic [DATA_WIDTH-1:0] rdseed_seed_o,

  input  logic                  clear_stats_i,
  output logic [CNT_WIDTH-1:0]  drbg_grants_o,
  output logic [CNT_WIDTH-1:0]  rdseed_grants_o,
  output logic                  busy_o
);

  localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    EMPTY       = 2'd0,
    ARB         = 2'd1,
    SEND_DRBG   = 2'd2,
    SEND_RDSEED = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [STREAK_W-1:0]   streak_q, streak_d;
  logic [CNT_WIDTH-1:0]  drbg_cnt_q, drbg_cnt_d;
  logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;

  logic force_rd;
  logic accept;
  logic drbg_xfer;
  logic rd_xfer;

  assign force_rd  = (streak_q == STREAK_MAX) && rdseed_ready_i;
  assign accept    = (state_q == EMPTY) && cond_valid_i;
  assign drbg_xfer = (state_q == SEND_DRBG) && drbg_ready_i;
  assign rd_xfer   = (state_q == SEND_RDSEED) && rdseed_ready_i;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; combinational blocks use blocking (=) to evaluate in order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (cond_valid_i) state_d = ARB;
      end
      ARB: begin
        if (drbg_req_i && !force_rd) state_d = SEND_DRBG;
        else if (rdseed_ready_i)     state_d = SEND_RDSEED;
      end
      // Destination is committed once chosen; only the consumer's ready matters.
      SEND_DRBG: begin
        if (drbg_ready_i) state_d = EMPTY;
      end
      SEND_RDSEED: begin
        if (rdseed_ready_i) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Moore outputs: valids and seed buses depend on state only, so they stay
  // stable while a consumer withholds ready.
  always_comb begin
    cond_ready_o   = 1'b0;
    drbg_valid_o   = 1'b0;
    rdseed_valid_o = 1'b0;
    drbg_seed_o    = '0;
    rdseed_seed_o  = '0;
    busy_o         = 1'b1;
    unique case (state_q)
      EMPTY: begin
        cond_ready_o = 1'b1;
        busy_o       = 1'b0;
      end
      SEND_DRBG: begin
        drbg_valid_o = 1'b1;
        drbg_seed_o  = hold_q;
      end
      SEND_RDSEED: begin
        rdseed_valid_o = 1'b1;
        rdseed_seed_o  = hold_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    hold_d = hold_q;
    if (accept) begin
      hold_d = cond_seed_i;
    end else if (drbg_xfer || rd_xfer) begin
      hold_d = '0;
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (drbg_xfer && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + STREAK_W'(1);
    end else if (rd_xfer) begin
      streak_d = '0;
    end
  end

  // A clear request wins over a same-cycle grant increment.
  always_comb begin
    drbg_cnt_d = drbg_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    if (clear_stats_i) begin
      drbg_cnt_d = '0;
      rd_cnt_d   = '0;
    end else begin
      if (drbg_xfer && (drbg_cnt_q != '1)) drbg_cnt_d = drbg_cnt_q + CNT_WIDTH'(1);
      if (rd_xfer && (rd_cnt_q != '1))     rd_cnt_d   = rd_cnt_q + CNT_WIDTH'(1);
    end
  end

  // NOTE: the holding register is key material, so it is explicitly reset and
  // zeroized after each transfer rather than left as don't-care storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q     <= '0;
      streak_q   <= '0;
      drbg_cnt_q <= '0;
      rd_cnt_q   <= '0;
    end else begin
      hold_q     <= hold_d;
      streak_q   <= streak_d;
      drbg_cnt_q <= drbg_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  assign drbg_grants_o   = drbg_cnt_q;
  assign rdseed_grants_o = rd_cnt_q;

  a_valid_exclusive : assert property (
    @(posedge clk) disable iff (rst) !(drbg_valid_o && rdseed_valid_o));

  a_drbg_stable : assert property (
    @(posedge clk) disable iff (rst)
    (drbg_valid_o && !drbg_ready_i) |=> (drbg_valid_o && $stable(drbg_seed_o)));

  a_rdseed_stable : assert property (
    @(posedge clk) disable iff (rst)
    (rdseed_valid_o && !rdseed_ready_i) |=> (rdseed_valid_o && $stable(rdseed_seed_o)));

endmodule

// File: tb/tb_seed_arbiter.sv
// Directed bench for seed_arbiter: table of single-seed transactions plus
// hand-written sequences for reset, stall, commit and counter corner cases.
module tb_seed_arbiter;

  localparam int DW = 256;
  localparam int CW = 4;  // narrow counters so saturation is reachable quickly

  logic          clk = 1'b0;
  logic          rst;
  logic          cond_valid_i;
  logic          cond_ready_o;
  logic [DW-1:0] cond_seed_i;
  logic          drbg_req_i;
  logic          drbg_ready_i;
  logic          drbg_valid_o;
  logic [DW-1:0] drbg_seed_o;
  logic          rdseed_ready_i;
  logic          rdseed_valid_o;
  logic [DW-1:0] rdseed_seed_o;
  logic          clear_stats_i;
  logic [CW-1:0] drbg_grants_o;
  logic [CW-1:0] rdseed_grants_o;
  logic          busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  seed_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(4), .CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .cond_valid_i    (cond_valid_i),
    .cond_ready_o    (cond_ready_o),
    .cond_seed_i     (cond_seed_i),
    .drbg_req_i      (drbg_req_i),
    .drbg_ready_i    (drbg_ready_i),
    .drbg_valid_o    (drbg_valid_o),
    .drbg_seed_o     (drbg_seed_o),
    .rdseed_ready_i  (rdseed_ready_i),
    .rdseed_valid_o  (rdseed_valid_o),
    .rdseed_seed_o   (rdseed_seed_o),
    .clear_stats_i   (clear_stats_i),
    .drbg_grants_o   (drbg_grants_o),
    .rdseed_grants_o (rdseed_grants_o),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] seed;
    logic          drbg_req;
    logic          rd_rdy;
    logic          exp_rd;   // 1: seed expected at RDSEED, 0: at DRBG
    logic [CW-1:0] exp_d;
    logic [CW-1:0] exp_r;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seed(input logic [DW-1:0] seed);
    cond_valid_i = 1'b1;
    cond_seed_i  = seed;
    tick();
    cond_valid_i = 1'b0;
    cond_seed_i  = '0;
  endtask

  // One full transaction with ready always high on the DRBG side.
  task automatic run_vec(input string tag, input vec_t v);
    int cyc = 0;
    while (!cond_ready_o && cyc < 10) begin
      tick();
      cyc++;
    end
    check({tag, "_cond_ready"}, DW'(cond_ready_o), DW'(1));
    drbg_req_i     = v.drbg_req;
    rdseed_ready_i = v.rd_rdy;
    drbg_ready_i   = 1'b1;
    load_seed(v.seed);
    cyc = 0;
    while (!drbg_valid_o && !rdseed_valid_o && cyc < 8) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, DW'(cyc), DW'(1));
    check({tag, "_dest"}, DW'({rdseed_valid_o, drbg_valid_o}), DW'(v.exp_rd ? 2'b10 : 2'b01));
    check({tag, "_data"}, v.exp_rd ? rdseed_seed_o : drbg_seed_o, v.seed);
    check({tag, "_other_zero"}, v.exp_rd ? drbg_seed_o : rdseed_seed_o, '0);
    tick();
    check({tag, "_drbg_cnt"}, DW'(drbg_grants_o), DW'(v.exp_d));
    check({tag, "_rd_cnt"}, DW'(rdseed_grants_o), DW'(v.exp_r));
    check({tag, "_ready_back"}, DW'(cond_ready_o), DW'(1));
    drbg_ready_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] seed;
    logic          bad;
    vec_t          v;

    // Starvation table: D x4, forced R, D x4, forced R.
    vecs[0] = '{{8{32'hC0DE_0001}}, 1'b1, 1'b1, 1'b0, 4'd1, 4'd0};
    vecs[1] = '{{8{32'hC0DE_0002}}, 1'b1, 1'b1, 1'b0, 4'd2, 4'd0};
    vecs[2] = '{{8{32'hC0DE_0003}}, 1'b1, 1'b1, 1'b0, 4'd3, 4'd0};
    vecs[3] = '{{8{32'hC0DE_0004}}, 1'b1, 1'b1, 1'b0, 4'd4, 4'd0};
    vecs[4] = '{{8{32'hC0DE_0005}}, 1'b1, 1'b1, 1'b1, 4'd4, 4'd1};
    vecs[5] = '{{8{32'hC0DE_0006}}, 1'b1, 1'b1, 1'b0, 4'd5, 4'd1};
    vecs[6] = '{{8{32'hC0DE_0007}}, 1'b1, 1'b1, 1'b0, 4'd6, 4'd1};
    vecs[7] = '{{8{32'hC0DE_0008}}, 1'b1, 1'b1, 1'b0, 4'd7, 4'd1};
    vecs[8] = '{{8{32'hC0DE_0009}}, 1'b1, 1'b1, 1'b0, 4'd8, 4'd1};
    vecs[9] = '{{8{32'hC0DE_000A}}, 1'b1, 1'b1, 1'b1, 4'd8, 4'd2};

    rst = 1'b1;
    cond_valid_i = 1'b0; cond_seed_i = '0;
    drbg_req_i = 1'b0; drbg_ready_i = 1'b0; rdseed_ready_i = 1'b0;
    clear_stats_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_cond_ready", DW'(cond_ready_o), DW'(1));
    check("rst_valids", DW'({drbg_valid_o, rdseed_valid_o}), DW'(0));
    check("rst_seeds", drbg_seed_o | rdseed_seed_o, '0);
    check("rst_busy", DW'(busy_o), DW'(0));
    check("rst_counts", DW'({drbg_grants_o, rdseed_grants_o}), DW'(0));

    // Basic DRBG delivery with both consumers eligible.
    seed = {32{8'hA5}};
    drbg_req_i = 1'b1; rdseed_ready_i = 1'b1; drbg_ready_i = 1'b1;
    load_seed(seed);
    check("basic_arb_no_valid", DW'({drbg_valid_o, rdseed_valid_o}), DW'(0));
    check("basic_arb_busy", DW'(busy_o), DW'(1));
    tick();
    check("basic_drbg_valid", DW'(drbg_valid_o), DW'(1));
    check("basic_rd_valid", DW'(rdseed_valid_o), DW'(0));
    check("basic_data", drbg_seed_o, seed);
    check("basic_cond_ready_low", DW'(cond_ready_o), DW'(0));
    tick();
    check("basic_drbg_cnt", DW'(drbg_grants_o), DW'(1));
    check("basic_cond_ready_back", DW'(cond_ready_o), DW'(1));
    check("basic_drbg_valid_gone", DW'(drbg_valid_o), DW'(0));

    // Asynchronous reset while a seed waits in SEND_DRBG.
    drbg_ready_i = 1'b0; rdseed_ready_i = 1'b0;
    load_seed({32{8'h5A}});
    tick();
    check("areset_pre_valid", DW'(drbg_valid_o), DW'(1));
    #2 rst = 1'b1;
    #1;
    check("areset_valids", DW'({drbg_valid_o, rdseed_valid_o}), DW'(0));
    check("areset_seeds", drbg_seed_o | rdseed_seed_o, '0);
    check("areset_cond_ready", DW'(cond_ready_o), DW'(1));
    check("areset_busy", DW'(busy_o), DW'(0));
    check("areset_counts", DW'({drbg_grants_o, rdseed_grants_o}), DW'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    drbg_ready_i = 1'b1;
    tick();
    check("areset_no_redelivery", DW'({drbg_valid_o, busy_o}), DW'(0));
    drbg_ready_i = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_vec($sformatf("starve%0d", i), vecs[i]);
    end

    // Hold in ARB with no eligible consumer.
    drbg_req_i = 1'b0; rdseed_ready_i = 1'b0;
    seed = {8{32'hDEAD_BEEF}};
    load_seed(seed);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (drbg_valid_o || rdseed_valid_o || cond_ready_o || !busy_o) bad = 1'b1;
      tick();
    end
    check("hold_arb_quiet", DW'(bad), DW'(0));
    rdseed_ready_i = 1'b1;
    tick();
    check("hold_rd_valid", DW'({rdseed_valid_o, drbg_valid_o}), DW'(2'b10));
    check("hold_rd_data", rdseed_seed_o, seed);
    tick();
    check("hold_rd_cnt", DW'(rdseed_grants_o), DW'(3));
    check("hold_drbg_cnt", DW'(drbg_grants_o), DW'(8));
    check("hold_cond_ready", DW'(cond_ready_o), DW'(1));

    // Committed DRBG destination survives req drop and RDSEED readiness.
    drbg_req_i = 1'b1; rdseed_ready_i = 1'b0; drbg_ready_i = 1'b0;
    seed = {4{64'h0123_4567_89AB_CDEF}};
    load_seed(seed);
    tick();
    check("commit_valid", DW'(drbg_valid_o), DW'(1));
    drbg_req_i = 1'b0; rdseed_ready_i = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!drbg_valid_o || rdseed_valid_o || drbg_seed_o !== seed) bad = 1'b1;
    end
    check("commit_stable", DW'(bad), DW'(0));
    drbg_ready_i = 1'b1;
    tick();
    drbg_ready_i = 1'b0;
    check("commit_drbg_cnt", DW'(drbg_grants_o), DW'(9));
    check("commit_rd_cnt", DW'(rdseed_grants_o), DW'(3));
    check("commit_no_rd_valid", DW'(rdseed_valid_o), DW'(0));
    check("commit_cond_ready", DW'(cond_ready_o), DW'(1));
    rdseed_ready_i = 1'b0;

    // Saturation: 16 DRBG grants on a 4-bit counter pin it at all-ones.
    clear_stats_i = 1'b1;
    tick();
    clear_stats_i = 1'b0;
    check("clear_counts", DW'({drbg_grants_o, rdseed_grants_o}), DW'(0));
    for (int i = 0; i < 16; i++) begin
      v = '{{8{32'h5EED_0000 + 32'(i)}}, 1'b1, 1'b0, 1'b0,
            (i < 15) ? CW'(i + 1) : CW'(15), CW'(0)};
      run_vec($sformatf("sat%0d", i), v);
    end
    check("sat_all_ones", DW'(drbg_grants_o), DW'(4'hF));

    // Clear coinciding with an RDSEED grant.
    drbg_req_i = 1'b0; rdseed_ready_i = 1'b1;
    load_seed({8{32'hFACE_0FF0}});
    tick();
    check("clrgrant_rd_valid", DW'(rdseed_valid_o), DW'(1));
    clear_stats_i = 1'b1;
    tick();
    clear_stats_i = 1'b0;
    check("clrgrant_drbg_cnt", DW'(drbg_grants_o), DW'(0));
    check("clrgrant_rd_cnt", DW'(rdseed_grants_o), DW'(0));
    check("clrgrant_cond_ready", DW'(cond_ready_o), DW'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
